piso_tx_ctrl: RTL and testbench

//  Serial transmit controller around a WIDTH-bit parallel-in/serial-out shift register.

---
 rtl/piso_tx_ctrl_pkg.sv | 19 +
 rtl/piso_shift_en.sv | 30 +++
 rtl/piso_tx_ctrl.sv | 119 +++++++++++
 tb/tb_piso_tx_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the serial transmit controller: state encoding,
// counter-width helper and the internal serial output bundle.
package piso_tx_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Width of a counter running 0..n-1; never below one bit so n<=1 still builds.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic data;
        logic valid;
    } ser_t;

endpackage

// File: rtl/piso_shift_en.sv
// WIDTH-bit parallel-in/serial-out register: load has priority over shift,
// shifting moves toward bit 0 and fills with zero.
module piso_shift_en
    import piso_tx_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    output logic             lsb
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_data;
        end else if (shift_en) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign lsb = shreg[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial transmit controller: accepts a word on valid/ready, sends it LSB
// first with DIV clocks per bit, then idles GAP_BITS bit-times before re-arming.
module piso_tx_ctrl
    import piso_tx_ctrl_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int DIV      = 4,
    parameter int GAP_BITS = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int GAP_CLKS = GAP_BITS * DIV;
    localparam int DW       = cnt_w(DIV);
    localparam int BW       = cnt_w(WIDTH);
    localparam int GW       = cnt_w(GAP_CLKS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          accept;
    logic          div_last;
    logic          bit_last;
    logic          gap_last;
    logic          shift_en;
    logic          shreg_lsb;
    ser_t          ser;

    assign data_ready = (state == ST_IDLE);
    assign accept     = data_valid && data_ready;
    assign div_last   = (div_cnt == DIV_LAST);
    assign bit_last   = (bit_cnt == BIT_LAST);
    assign gap_last   = (gap_cnt == GAP_LAST);
    // The last bit is never shifted out: the state change itself ends the frame.
    assign shift_en   = (state == ST_SHIFT) && div_last && !bit_last;

    piso_shift_en #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (accept),
        .shift_en (shift_en),
        .load_data(data_in),
        .lsb      (shreg_lsb)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_last) begin
                            if (GAP_CLKS == 0) begin
                                state      <= ST_IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        state      <= ST_IDLE;
                        gap_cnt    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ser.valid    = (state == ST_SHIFT);
    assign ser.data     = ser.valid && shreg_lsb;
    assign serial_out   = ser.data;
    assign serial_valid = ser.valid;
    assign busy         = (state == ST_SHIFT) || (state == ST_GAP);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench: two builds (DIV=4/GAP=1 and DIV=1/GAP=0) driven with random
// words, random back-pressure and resets; expected per-cycle outputs are queued.
module tb_piso_tx_ctrl;

    localparam int W     = 6;
    localparam int N_CYC = 600;

    localparam int K_IDLE = 0;
    localparam int K_BIT  = 1;
    localparam int K_GAP  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DIV_G = (g == 0) ? 4 : 1;
        localparam int GAP_G = (g == 0) ? 1 : 0;
        localparam int FRAME = 1 + W * DIV_G + GAP_G * DIV_G;
        localparam logic [W-1:0] FIRST = (g == 0) ? 6'b101101 : 6'b000001;

        logic         clear_n;
        logic [W-1:0] data_in;
        logic         data_valid;
        logic         data_ready;
        logic         serial_out;
        logic         serial_valid;
        logic         busy;
        logic         frame_done;

        exp_t q[$];
        int   next_ready;
        int   last_acc;
        int   n_acc;
        bit   exp_ready;
        bit   mon_en;
        bit   forced;
        bit   fin;

        piso_tx_ctrl #(
            .WIDTH   (W),
            .DIV     (DIV_G),
            .GAP_BITS(GAP_G)
        ) u_dut (
            .clk         (clk),
            .clear_n     (clear_n),
            .data_in     (data_in),
            .data_valid  (data_valid),
            .data_ready  (data_ready),
            .serial_out  (serial_out),
            .serial_valid(serial_valid),
            .busy        (busy),
            .frame_done  (frame_done)
        );

        // Reference: an accepted word becomes W bit-times of DIV clocks each,
        // then the gap, then a completion pulse on the clock ready returns.
        task automatic push_frame(input int c, input logic [W-1:0] w);
            for (int b = 0; b < W; b++)
                for (int k = 0; k < DIV_G; k++)
                    q.push_back('{c + 1 + b * DIV_G + k, K_BIT, int'(w[b])});
            for (int k = 0; k < GAP_G * DIV_G; k++)
                q.push_back('{c + 1 + W * DIV_G + k, K_GAP, 0});
            q.push_back('{c + FRAME, K_DONE, 0});
            next_ready = c + FRAME;
            last_acc   = c;
            n_acc++;
        endtask

        initial begin
            clear_n    = 1'b0;
            data_valid = 1'b0;
            data_in    = '0;
            mon_en     = 1'b0;
            forced     = 1'b0;
            fin        = 1'b0;
            n_acc      = 0;
            last_acc   = 0;
            exp_ready  = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1;
            next_ready = cyc;
            mon_en     = 1'b1;
            for (int n = 0; n < N_CYC + FRAME + 4; n++) begin
                logic do_rst;
                exp_ready  = (cyc >= next_ready);
                data_in    = (n == 0) ? FIRST : W'($urandom);
                data_valid = (n >= N_CYC) ? 1'b0 :
                             (n < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
                do_rst = 1'b0;
                if (!forced && n_acc == 3 && cyc == last_acc + 1 + 3 * DIV_G) begin
                    do_rst = 1'b1;
                    forced = 1'b1;
                end else if (n > 100 && n < N_CYC && $urandom_range(0, 149) == 0) begin
                    do_rst = 1'b1;
                end
                clear_n = !do_rst;
                if (do_rst) begin
                    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
                    next_ready = cyc + 1;
                end else if (data_valid && exp_ready) begin
                    push_frame(cyc, data_in);
                end
                @(posedge clk);
                #1;
            end
            chk($sformatf("u%0d.queue_left", g), q.size(), 0);
            chk($sformatf("u%0d.forced_reset_hit", g), int'(forced), 1);
            fin = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (mon_en && !fin) begin
                if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
                else e = '{cyc, K_IDLE, 0};
                chk($sformatf("u%0d.serial_valid c%0d", g, cyc), int'(serial_valid),
                    int'(e.kind == K_BIT));
                chk($sformatf("u%0d.serial_out c%0d", g, cyc), int'(serial_out),
                    (e.kind == K_BIT) ? e.val : 0);
                chk($sformatf("u%0d.busy c%0d", g, cyc), int'(busy),
                    int'(e.kind == K_BIT || e.kind == K_GAP));
                chk($sformatf("u%0d.frame_done c%0d", g, cyc), int'(frame_done),
                    int'(e.kind == K_DONE));
                chk($sformatf("u%0d.data_ready c%0d", g, cyc), int'(data_ready),
                    int'(exp_ready));
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(g_inst[0].fin && g_inst[1].fin); i++)
            @(posedge clk);
        if (!(g_inst[0].fin && g_inst[1].fin)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: drivers finished=%0d/%0d, expected 1/1",
                     g_inst[0].fin, g_inst[1].fin);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
